// File: rtl/matrix_pkg.sv
// Constants and arbiter state encodings shared by the LED matrix driver and its write arbiter.
// Pure declarations; no latency or flow-control behaviour of its own.
package matrix_pkg;

  localparam int COLUMNS_PER_BOARD = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  function automatic int bytes_total(input int boards, input int rows);
    return boards * COLUMNS_PER_BOARD * rows;
  endfunction

endpackage

// File: rtl/matrix_write_arbiter_if.sv
// Two-requester write bus into the pixel-memory port plus arbiter status outputs.
// Requester beats move on valid&ready; the memory side has no backpressure.
interface matrix_write_arbiter_if #(
  parameter int ADDR_WIDTH = 9
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_last;
  logic [ADDR_WIDTH-1:0] req0_address;
  logic [7:0]            req0_data;
  logic [ADDR_WIDTH-1:0] req1_address;
  logic [7:0]            req1_data;
  logic [ADDR_WIDTH-1:0] address_out;
  logic [7:0]            data_out;
  logic                  write_strobe_out;
  logic [1:0]            grant;
  logic                  timeout_pulse;
  logic                  range_err_pulse;

  modport master (
    output req_valid, req_last, req0_address, req0_data, req1_address, req1_data,
    input  req_ready, address_out, data_out, write_strobe_out, grant,
           timeout_pulse, range_err_pulse
  );

  modport slave (
    input  req_valid, req_last, req0_address, req0_data, req1_address, req1_data,
    output req_ready, address_out, data_out, write_strobe_out, grant,
           timeout_pulse, range_err_pulse
  );
endinterface

// File: rtl/matrix_write_arbiter.sv
// Burst-locked round-robin arbiter for the pixel-memory write port; one cycle to arbitrate,
// 1-cycle write latency, 1 write/cycle sustained; non-owner is held off with ready=0.
module matrix_write_arbiter
  import matrix_pkg::*;
#(
  parameter int BOARDS     = 3,
  parameter int ROWS       = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_write_arbiter_if.slave  bus
);

  localparam int BYTES_TOTAL = bytes_total(BOARDS, ROWS);
  localparam int CW          = $clog2(TIMEOUT);
  localparam int TMAX        = TIMEOUT - 1;
  localparam logic [ADDR_WIDTH:0] LIMIT   = BYTES_TOTAL[ADDR_WIDTH:0];
  localparam logic [CW-1:0]       CNT_MAX = TMAX[CW-1:0];

  arb_state_t            state, next_state;
  logic                  last_owner;
  logic [CW-1:0]         idle_cnt;

  logic                  owning;
  logic                  own_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_data;
  logic                  xfer;
  logic                  in_range;
  logic                  timeout_hit;
  logic                  burst_end;

  logic [ADDR_WIDTH-1:0] address_q;
  logic [7:0]            data_q;
  logic                  strobe_q;
  logic                  timeout_q;
  logic                  range_err_q;

  always_comb begin
    owning      = (state == ARB_OWN0) || (state == ARB_OWN1);
    own_idx     = (state == ARB_OWN1);
    sel_valid   = own_idx ? bus.req_valid[1] : bus.req_valid[0];
    sel_last    = own_idx ? bus.req_last[1]  : bus.req_last[0];
    sel_addr    = own_idx ? bus.req1_address : bus.req0_address;
    sel_data    = own_idx ? bus.req1_data    : bus.req0_data;
    xfer        = owning && sel_valid;
    in_range    = {1'b0, sel_addr} < LIMIT;
    // A beat arriving on the revocation cycle takes priority over the timeout.
    timeout_hit = owning && !xfer && (idle_cnt == CNT_MAX);
    burst_end   = (xfer && sel_last) || timeout_hit;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        case (bus.req_valid)
          2'b01:   next_state = ARB_OWN0;
          2'b10:   next_state = ARB_OWN1;
          2'b11:   next_state = last_owner ? ARB_OWN0 : ARB_OWN1;
          default: next_state = ARB_IDLE;
        endcase
      end
      ARB_OWN0, ARB_OWN1: begin
        if (burst_end) next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      last_owner  <= 1'b1;
      idle_cnt    <= '0;
      address_q   <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      timeout_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (owning && burst_end) last_owner <= own_idx;

      if (!owning || xfer || timeout_hit) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + 1'b1;

      if (xfer && in_range) begin
        address_q <= sel_addr;
        data_q    <= sel_data;
      end
      strobe_q    <= xfer && in_range;
      range_err_q <= xfer && !in_range;
      timeout_q   <= timeout_hit;
    end
  end

  assign bus.grant            = {state == ARB_OWN1, state == ARB_OWN0};
  assign bus.req_ready        = {state == ARB_OWN1, state == ARB_OWN0};
  assign bus.address_out      = address_q;
  assign bus.data_out         = data_q;
  assign bus.write_strobe_out = strobe_q;
  assign bus.timeout_pulse    = timeout_q;
  assign bus.range_err_pulse  = range_err_q;

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// Directed self-checking bench for matrix_write_arbiter, built with TIMEOUT=8.
module tb_matrix_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bad_grant = 0;

  always #5 clk = ~clk;

  matrix_write_arbiter_if #(.ADDR_WIDTH(9)) bus ();

  matrix_write_arbiter #(
    .BOARDS(3), .ROWS(4), .ADDR_WIDTH(9), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) if (!rst && bus.grant == 2'b11) bad_grant++;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [8:0] a, input logic [7:0] d, input logic l);
    bus.req_valid[0] = v;
    bus.req0_address = a;
    bus.req0_data    = d;
    bus.req_last[0]  = l;
  endtask

  task automatic set1(input logic v, input logic [8:0] a, input logic [7:0] d, input logic l);
    bus.req_valid[1] = v;
    bus.req1_address = a;
    bus.req1_data    = d;
    bus.req_last[1]  = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Four-beat req0 burst at addresses 0..3 with data 8'h10..8'h13.
  task automatic burst0_four(input string tag);
    set0(1'b1, 9'd0, 8'h10, 1'b0);
    tick();
    chk_eq({tag, "_grant_arb"}, 32'(bus.grant), 32'h1);
    chk_eq({tag, "_strobe_arb"}, 32'(bus.write_strobe_out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 9'(i), 8'(8'h10 + i), i == 3);
      tick();
      chk_eq({tag, "_strobe"}, 32'(bus.write_strobe_out), 32'h1);
      chk_eq({tag, "_addr"}, 32'(bus.address_out), 32'(i));
      chk_eq({tag, "_data"}, 32'(bus.data_out), 32'(8'h10 + i));
      chk_eq({tag, "_grant"}, 32'(bus.grant), (i == 3) ? 32'h0 : 32'h1);
    end
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    tick();
    chk_eq({tag, "_strobe_after"}, 32'(bus.write_strobe_out), 32'h0);
    chk_eq({tag, "_addr_hold"}, 32'(bus.address_out), 32'h3);
  endtask

  initial begin
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    set1(1'b0, 9'd0, 8'h00, 1'b0);
    tick();
    tick();
    chk_eq("rst_grant", 32'(bus.grant), 32'h0);
    chk_eq("rst_ready", 32'(bus.req_ready), 32'h0);
    chk_eq("rst_addr", 32'(bus.address_out), 32'h0);
    chk_eq("rst_data", 32'(bus.data_out), 32'h0);
    chk_eq("rst_strobe", 32'(bus.write_strobe_out), 32'h0);
    chk_eq("rst_tmo", 32'(bus.timeout_pulse), 32'h0);
    chk_eq("rst_rerr", 32'(bus.range_err_pulse), 32'h0);
    rst = 1'b0;

    // Test 1: req0 alone
    burst0_four("t1");

    // Test 2: tie from reset, req0 wins, then req1, then tie again
    do_reset();
    set0(1'b1, 9'd10, 8'hA0, 1'b0);
    set1(1'b1, 9'd20, 8'hB0, 1'b0);
    tick();
    chk_eq("t2_grant0", 32'(bus.grant), 32'h1);
    chk_eq("t2_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    chk_eq("t2_addr10", 32'(bus.address_out), 32'd10);
    set0(1'b1, 9'd11, 8'hA1, 1'b1);
    tick();
    chk_eq("t2_addr11", 32'(bus.address_out), 32'd11);
    chk_eq("t2_idle0", 32'(bus.grant), 32'h0);
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    tick();
    chk_eq("t2_grant1", 32'(bus.grant), 32'h2);
    chk_eq("t2_strobe_arb", 32'(bus.write_strobe_out), 32'h0);
    tick();
    chk_eq("t2_addr20", 32'(bus.address_out), 32'd20);
    chk_eq("t2_data20", 32'(bus.data_out), 32'hB0);
    set1(1'b1, 9'd21, 8'hB1, 1'b1);
    tick();
    chk_eq("t2_addr21", 32'(bus.address_out), 32'd21);
    chk_eq("t2_idle1", 32'(bus.grant), 32'h0);
    set0(1'b1, 9'd12, 8'hA2, 1'b1);
    set1(1'b1, 9'd22, 8'hB2, 1'b1);
    tick();
    chk_eq("t2_tie_again", 32'(bus.grant), 32'h1);
    tick();
    chk_eq("t2_addr12", 32'(bus.address_out), 32'd12);
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    tick();
    chk_eq("t2_rr_grant1", 32'(bus.grant), 32'h2);
    tick();
    chk_eq("t2_addr22", 32'(bus.address_out), 32'd22);
    set1(1'b0, 9'd0, 8'h00, 1'b0);
    tick();

    // Test 3: range boundary on req1
    set1(1'b1, 9'd191, 8'h55, 1'b0);
    tick();
    chk_eq("t3_grant", 32'(bus.grant), 32'h2);
    tick();
    chk_eq("t3_strobe191", 32'(bus.write_strobe_out), 32'h1);
    chk_eq("t3_addr191", 32'(bus.address_out), 32'd191);
    chk_eq("t3_rerr191", 32'(bus.range_err_pulse), 32'h0);
    set1(1'b1, 9'd192, 8'h66, 1'b1);
    tick();
    chk_eq("t3_strobe192", 32'(bus.write_strobe_out), 32'h0);
    chk_eq("t3_rerr192", 32'(bus.range_err_pulse), 32'h1);
    chk_eq("t3_addr_hold", 32'(bus.address_out), 32'd191);
    chk_eq("t3_data_hold", 32'(bus.data_out), 32'h55);
    chk_eq("t3_idle", 32'(bus.grant), 32'h0);
    set1(1'b0, 9'd0, 8'h00, 1'b0);
    tick();
    chk_eq("t3_rerr_clear", 32'(bus.range_err_pulse), 32'h0);

    // Test 4: timeout after 8 idle cycles, pending req1 then granted
    set0(1'b1, 9'd5, 8'h05, 1'b0);
    tick();
    chk_eq("t4_grant0", 32'(bus.grant), 32'h1);
    tick();
    chk_eq("t4_addr5", 32'(bus.address_out), 32'd5);
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    set1(1'b1, 9'd30, 8'h30, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_eq("t4_wait_tmo", 32'(bus.timeout_pulse), 32'h0);
      chk_eq("t4_wait_grant", 32'(bus.grant), 32'h1);
    end
    tick();
    chk_eq("t4_tmo", 32'(bus.timeout_pulse), 32'h1);
    chk_eq("t4_grant_revoked", 32'(bus.grant), 32'h0);
    chk_eq("t4_no_strobe", 32'(bus.write_strobe_out), 32'h0);
    tick();
    chk_eq("t4_tmo_once", 32'(bus.timeout_pulse), 32'h0);
    chk_eq("t4_grant1", 32'(bus.grant), 32'h2);
    tick();
    chk_eq("t4_addr30", 32'(bus.address_out), 32'd30);
    chk_eq("t4_strobe30", 32'(bus.write_strobe_out), 32'h1);
    set1(1'b0, 9'd0, 8'h00, 1'b0);
    tick();

    // Test 5: transfer exactly on the revocation cycle
    set0(1'b1, 9'd6, 8'h77, 1'b0);
    tick();
    tick();
    chk_eq("t5_addr6", 32'(bus.address_out), 32'd6);
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    set0(1'b1, 9'd7, 8'h78, 1'b0);
    tick();
    chk_eq("t5_strobe", 32'(bus.write_strobe_out), 32'h1);
    chk_eq("t5_addr7", 32'(bus.address_out), 32'd7);
    chk_eq("t5_no_tmo", 32'(bus.timeout_pulse), 32'h0);
    chk_eq("t5_grant", 32'(bus.grant), 32'h1);
    set0(1'b1, 9'd8, 8'h79, 1'b1);
    tick();
    chk_eq("t5_addr8", 32'(bus.address_out), 32'd8);
    chk_eq("t5_no_tmo2", 32'(bus.timeout_pulse), 32'h0);
    chk_eq("t5_idle", 32'(bus.grant), 32'h0);
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    tick();

    // Test 6: reset mid-burst, then a fresh burst
    set0(1'b1, 9'd9, 8'h99, 1'b0);
    tick();
    tick();
    chk_eq("t6_addr9", 32'(bus.address_out), 32'd9);
    set0(1'b1, 9'd10, 8'h9A, 1'b0);
    rst = 1'b1;
    tick();
    chk_eq("t6_grant", 32'(bus.grant), 32'h0);
    chk_eq("t6_ready", 32'(bus.req_ready), 32'h0);
    chk_eq("t6_strobe", 32'(bus.write_strobe_out), 32'h0);
    chk_eq("t6_addr", 32'(bus.address_out), 32'h0);
    rst = 1'b0;
    set0(1'b0, 9'd0, 8'h00, 1'b0);
    tick();
    burst0_four("t6b");

    chk_eq("grant_never_11", 32'(bad_grant), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
